// File: rtl/clk_rst_sequencer_if.sv
// Signal bundle between the clock/reset sequencer and the surrounding clock tree and fabric.
// master: the sequencer itself; slave: the environment feeding lock/button/soft-reset inputs.
interface clk_rst_sequencer_if;
  logic       PLL_LOCK;
  logic       EXT_RESET_N;
  logic       SOFT_RESET_REQ;
  logic       FABRIC_RESET_N;
  logic       CORE_RESET_N;
  logic       INIT_DONE;
  logic       LOCK_TIMEOUT;
  logic [2:0] STATE;

  modport master (
    input  PLL_LOCK, EXT_RESET_N, SOFT_RESET_REQ,
    output FABRIC_RESET_N, CORE_RESET_N, INIT_DONE, LOCK_TIMEOUT, STATE
  );

  modport slave (
    output PLL_LOCK, EXT_RESET_N, SOFT_RESET_REQ,
    input  FABRIC_RESET_N, CORE_RESET_N, INIT_DONE, LOCK_TIMEOUT, STATE
  );
endinterface

// File: rtl/clk_rst_sequencer.sv
// Reset/clock-qualification sequencer: waits for stable CCC lock, releases fabric then core reset.
// Optional macro CLK_RST_SEQ_DEBOUNCE_EN adds a low-time filter on the board reset button.
module clk_rst_sequencer #(
  parameter int unsigned LOCK_WAIT       = 16,
  parameter int unsigned SETTLE_CYCLES   = 32,
  parameter int unsigned HOLD_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 50000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  clk_rst_sequencer_if.master   bus
);

  localparam int LOCK_W   = $clog2(LOCK_WAIT + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);
  localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [LOCK_W-1:0]   LOCK_MAX   = LOCK_W'(LOCK_WAIT);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [HOLD_W-1:0]   HOLD_MAX   = HOLD_W'(HOLD_CYCLES);
  localparam logic [TMO_W-1:0]    TMO_MAX    = TMO_W'(TIMEOUT_CYCLES);

  if (LOCK_WAIT < 1 || SETTLE_CYCLES < 1 || HOLD_CYCLES < 1 ||
      TIMEOUT_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("clk_rst_sequencer: all cycle-count parameters must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_REL_FABRIC = 3'd2,
    ST_REL_CORE   = 3'd3,
    ST_RUN        = 3'd4,
    ST_ASSERT     = 3'd5
  } state_t;

  state_t              state;
  logic                fabric_rst_n;
  logic                core_rst_n;
  logic                init_done;
  logic                lock_timeout;
  logic [LOCK_W-1:0]   lock_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [TMO_W-1:0]    tmo_cnt;

  logic lock_p0, lock_p1;
  logic ext_p0, ext_p1;
  logic ext_evt;
  logic rst_evt;
  logic enter_assert;

  // Stage boundary: two-flop synchronizers for the asynchronous lock and button inputs
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
      ext_p0  <= 1'b0;
      ext_p1  <= 1'b0;
    end else begin
      lock_p0 <= bus.PLL_LOCK;
      lock_p1 <= lock_p0;
      ext_p0  <= bus.EXT_RESET_N;
      ext_p1  <= ext_p0;
    end
  end

`ifdef CLK_RST_SEQ_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [DEB_W-1:0] deb_cnt;
  logic             ext_low;

  // Button press counts only after a full run of low samples; release is immediate
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      deb_cnt <= '0;
      ext_low <= 1'b0;
    end else if (ext_p1) begin
      deb_cnt <= '0;
      ext_low <= 1'b0;
    end else begin
      if (deb_cnt != DEB_MAX) deb_cnt <= deb_cnt + DEB_W'(1);
      if (deb_cnt == DEB_LAST) ext_low <= 1'b1;
    end
  end

  assign ext_evt = ext_low;
`else
  assign ext_evt = ~ext_p1;
`endif

  assign rst_evt      = ~lock_p1 | ext_evt | (bus.SOFT_RESET_REQ & (state == ST_RUN));
  assign enter_assert = rst_evt & ((state == ST_REL_FABRIC) | (state == ST_REL_CORE) |
                                   (state == ST_RUN));

  // Stage boundary: sequencer state and registered reset outputs
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state        <= ST_IDLE;
      fabric_rst_n <= 1'b0;
      core_rst_n   <= 1'b0;
      init_done    <= 1'b0;
      lock_timeout <= 1'b0;
      lock_cnt     <= '0;
      settle_cnt   <= '0;
      hold_cnt     <= '0;
      tmo_cnt      <= '0;
    end else if (enter_assert) begin
      state        <= ST_ASSERT;
      fabric_rst_n <= 1'b0;
      core_rst_n   <= 1'b0;
      init_done    <= 1'b0;
      hold_cnt     <= HOLD_MAX;
    end else begin
      case (state)
        ST_IDLE: begin
          fabric_rst_n <= 1'b0;
          core_rst_n   <= 1'b0;
          init_done    <= 1'b0;
          lock_cnt     <= '0;
          tmo_cnt      <= '0;
          state        <= ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_p1 && !ext_evt) begin
            if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + LOCK_W'(1);
          end else begin
            lock_cnt <= '0;
          end
          // Timeout only flags; the wait for lock continues indefinitely
          if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TMO_W'(1);
          else                    lock_timeout <= 1'b1;
          if (lock_cnt == LOCK_MAX) begin
            state        <= ST_REL_FABRIC;
            fabric_rst_n <= 1'b1;
            settle_cnt   <= '0;
          end
        end
        ST_REL_FABRIC: begin
          if (settle_cnt == SETTLE_MAX) begin
            state      <= ST_REL_CORE;
            core_rst_n <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
          end
        end
        ST_REL_CORE: begin
          state     <= ST_RUN;
          init_done <= 1'b1;
        end
        ST_RUN: begin
          init_done <= 1'b1;
        end
        ST_ASSERT: begin
          if (rst_evt) begin
            hold_cnt <= HOLD_MAX;
          end else if (hold_cnt == '0) begin
            state    <= ST_WAIT_LOCK;
            lock_cnt <= '0;
            tmo_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        default: begin
          state        <= ST_IDLE;
          fabric_rst_n <= 1'b0;
          core_rst_n   <= 1'b0;
          init_done    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.FABRIC_RESET_N = fabric_rst_n;
  assign bus.CORE_RESET_N   = core_rst_n;
  assign bus.INIT_DONE      = init_done;
  assign bus.LOCK_TIMEOUT   = lock_timeout;
  assign bus.STATE          = state;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed bench for clk_rst_sequencer: cold start, lock glitches/loss, timeout, soft and button resets.
// Build with CLK_RST_SEQ_DEBOUNCE_EN defined to exercise the debounced button path.
module tb_clk_rst_sequencer;

  logic clk;
  logic resetn;
  int   n_tests;
  int   n_fail;

  clk_rst_sequencer_if bus ();

  clk_rst_sequencer dut (
    .CLK    (clk),
    .RESETN (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input logic lock);
    resetn             = 1'b0;
    bus.PLL_LOCK       = lock;
    bus.EXT_RESET_N    = 1'b1;
    bus.SOFT_RESET_REQ = 1'b0;
    step(2);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200 && !bus.INIT_DONE; i++) step(1);
    check_val(tag, bus.INIT_DONE, 1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Cold start with lock already high
    hold_reset(1'b1);
    check_val("rst_fabric", bus.FABRIC_RESET_N, 0);
    check_val("rst_core", bus.CORE_RESET_N, 0);
    check_val("rst_done", bus.INIT_DONE, 0);
    check_val("rst_tmo", bus.LOCK_TIMEOUT, 0);
    check_val("rst_state", bus.STATE, 0);
    resetn = 1'b1;
    step(1);
    check_val("cs_state_wait", bus.STATE, 1);
    step(17);
    check_val("cs_fabric_e18", bus.FABRIC_RESET_N, 0);
    step(1);
    check_val("cs_fabric_e19", bus.FABRIC_RESET_N, 1);
    check_val("cs_state_relf", bus.STATE, 2);
    step(32);
    check_val("cs_core_e51", bus.CORE_RESET_N, 0);
    step(1);
    check_val("cs_core_e52", bus.CORE_RESET_N, 1);
    check_val("cs_state_relc", bus.STATE, 3);
    check_val("cs_done_e52", bus.INIT_DONE, 0);
    step(1);
    check_val("cs_done_e53", bus.INIT_DONE, 1);
    check_val("cs_state_run", bus.STATE, 4);

    // Asynchronous reset assertion in RUN, between clock edges
    resetn = 1'b0;
    #2;
    check_val("async_fabric", bus.FABRIC_RESET_N, 0);
    check_val("async_done", bus.INIT_DONE, 0);
    check_val("async_state", bus.STATE, 0);

    // Software reset in RUN takes effect on the next edge
    hold_reset(1'b1);
    resetn = 1'b1;
    step(53);
    check_val("soft_pre_done", bus.INIT_DONE, 1);
    bus.SOFT_RESET_REQ = 1'b1;
    step(1);
    bus.SOFT_RESET_REQ = 1'b0;
    check_val("soft_state", bus.STATE, 5);
    check_val("soft_fabric", bus.FABRIC_RESET_N, 0);
    check_val("soft_core", bus.CORE_RESET_N, 0);
    wait_done("soft_recover");

    // One-cycle lock loss in RUN: assert 3 edges later, hold, re-sequence
    bus.PLL_LOCK = 1'b0;
    step(1);
    bus.PLL_LOCK = 1'b1;
    step(1);
    check_val("ll_state_e2", bus.STATE, 4);
    step(1);
    check_val("ll_state_e3", bus.STATE, 5);
    check_val("ll_fabric", bus.FABRIC_RESET_N, 0);
    check_val("ll_core", bus.CORE_RESET_N, 0);
    check_val("ll_done", bus.INIT_DONE, 0);
    step(8);
    check_val("ll_hold_e8", bus.STATE, 5);
    step(1);
    check_val("ll_hold_e9", bus.STATE, 1);
    step(16);
    check_val("ll_fabric_e25", bus.FABRIC_RESET_N, 0);
    step(1);
    check_val("ll_fabric_e26", bus.FABRIC_RESET_N, 1);
    step(34);
    check_val("ll_done_e60", bus.INIT_DONE, 1);

    // Lock drop and soft request landing on the same edge: one hold period only
    bus.PLL_LOCK = 1'b0;
    step(1);
    bus.PLL_LOCK = 1'b1;
    step(1);
    bus.SOFT_RESET_REQ = 1'b1;
    step(1);
    bus.SOFT_RESET_REQ = 1'b0;
    check_val("sim_state", bus.STATE, 5);
    step(8);
    check_val("sim_hold_e8", bus.STATE, 5);
    step(1);
    check_val("sim_hold_e9", bus.STATE, 1);
    wait_done("sim_recover");

`ifdef CLK_RST_SEQ_DEBOUNCE_EN
    // Button low for one cycle short of the filter, then exactly the filter length
    bus.EXT_RESET_N = 1'b0;
    step(999);
    bus.EXT_RESET_N = 1'b1;
    step(10);
    check_val("deb_999_state", bus.STATE, 4);
    bus.EXT_RESET_N = 1'b0;
    step(1000);
    bus.EXT_RESET_N = 1'b1;
    step(2);
    check_val("deb_1000_e1002", bus.STATE, 4);
    step(1);
    check_val("deb_1000_e1003", bus.STATE, 5);
    wait_done("deb_recover");
`else
    // Button low for one cycle: visible after the synchronizer
    bus.EXT_RESET_N = 1'b0;
    step(1);
    bus.EXT_RESET_N = 1'b1;
    step(1);
    check_val("ext_state_e2", bus.STATE, 4);
    step(1);
    check_val("ext_state_e3", bus.STATE, 5);
    check_val("ext_fabric", bus.FABRIC_RESET_N, 0);
    wait_done("ext_recover");
`endif

    // Lock glitch during WAIT_LOCK restarts the qualification count; soft request ignored
    hold_reset(1'b0);
    resetn = 1'b1;
    step(1);
    check_val("gl_state_wait", bus.STATE, 1);
    bus.PLL_LOCK = 1'b1;
    step(4);
    bus.SOFT_RESET_REQ = 1'b1;
    step(1);
    bus.SOFT_RESET_REQ = 1'b0;
    check_val("gl_soft_ignored", bus.STATE, 1);
    step(5);
    bus.PLL_LOCK = 1'b0;
    step(1);
    bus.PLL_LOCK = 1'b1;
    step(8);
    check_val("gl_fabric_e20", bus.FABRIC_RESET_N, 0);
    step(10);
    check_val("gl_fabric_e30", bus.FABRIC_RESET_N, 0);
    step(1);
    check_val("gl_fabric_e31", bus.FABRIC_RESET_N, 1);

    // No lock: sticky timeout, sequence still completes once lock arrives
    hold_reset(1'b0);
    resetn = 1'b1;
    step(49990);
    check_val("tmo_e49990", bus.LOCK_TIMEOUT, 0);
    step(20);
    check_val("tmo_e50010", bus.LOCK_TIMEOUT, 1);
    step(9990);
    check_val("tmo_e60000", bus.LOCK_TIMEOUT, 1);
    check_val("tmo_state", bus.STATE, 1);
    bus.PLL_LOCK = 1'b1;
    step(53);
    check_val("tmo_done", bus.INIT_DONE, 1);
    check_val("tmo_sticky", bus.LOCK_TIMEOUT, 1);
    hold_reset(1'b1);
    check_val("tmo_cleared", bus.LOCK_TIMEOUT, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
